// File: rtl/mem_fault_trap_ctrl_pkg.sv
// Shared definitions for the memory-fault trap controller and the memory checker.
// Holds the privilege mode encodings, the trap cause bits, the reserved-area
// boundary and the trap sequencer state type.
package mem_fault_trap_ctrl_pkg;

    localparam logic [1:0]  MODE_KERNEL  = 2'b00;
    localparam logic [1:0]  MODE_USER    = 2'b01;

    localparam logic [1:0]  CAUSE_PC     = 2'b01;
    localparam logic [1:0]  CAUSE_MEM    = 2'b10;

    // Lowest address user code may touch; shared with the memory checker.
    localparam logic [15:0] RESERVE_AREA = 16'h0100;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_SAVE,
        ST_VECTOR
    } trap_state_t;

    // Both flags may fire together, so the cause is the OR of the single-fault codes.
    function automatic logic [1:0] fault_cause(input logic pc_flag, input logic mem_flag);
        return (pc_flag ? CAUSE_PC : 2'b00) | (mem_flag ? CAUSE_MEM : 2'b00);
    endfunction

endpackage

// File: rtl/mem_fault_trap_ctrl_if.sv
// Bus between the trap controller and the checker / pipeline.
//   Illegal_PC, Illegal_Memory, Fault_PC, Fault_Addr : fault report from the checker
//   Rti, Flush_Done                                  : pipeline status
//   Mode                                             : privilege mode (checker, decode)
//   Flush, Stall, Redirect, Redirect_PC              : pipeline control
//   EPC, Cause, Bad_Addr, Fault_Count                : trap state read by the handler
// modport master : the trap controller; modport slave : checker / pipeline side.
interface mem_fault_trap_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             Illegal_PC;
    logic             Illegal_Memory;
    logic [15:0]      Fault_PC;
    logic [15:0]      Fault_Addr;
    logic             Rti;
    logic             Flush_Done;
    logic [1:0]       Mode;
    logic             Flush;
    logic             Stall;
    logic             Redirect;
    logic [15:0]      Redirect_PC;
    logic [15:0]      EPC;
    logic [1:0]       Cause;
    logic [15:0]      Bad_Addr;
    logic [CNT_W-1:0] Fault_Count;

    modport master (
        input  Illegal_PC, Illegal_Memory, Fault_PC, Fault_Addr, Rti, Flush_Done,
        output Mode, Flush, Stall, Redirect, Redirect_PC, EPC, Cause, Bad_Addr, Fault_Count
    );

    modport slave (
        output Illegal_PC, Illegal_Memory, Fault_PC, Fault_Addr, Rti, Flush_Done,
        input  Mode, Flush, Stall, Redirect, Redirect_PC, EPC, Cause, Bad_Addr, Fault_Count
    );

endinterface

// File: rtl/mem_fault_trap_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one unless already all-ones
//   clear      : return to zero (wins over inc)
//   cnt        : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order always_ff blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_fault_trap_ctrl.sv
// Precise trap sequencer for user-mode memory/PC faults.
// A fault accepted in user mode flushes the pipeline, records EPC / Cause /
// Bad_Addr, drops to kernel mode and redirects fetch to TRAP_VECTOR. A
// return-from-trap in kernel mode redirects fetch to EPC and re-enters user mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master side of mem_fault_trap_ctrl_if (see interface header)
module mem_fault_trap_ctrl
    import mem_fault_trap_ctrl_pkg::*;
#(
    parameter logic [15:0] TRAP_VECTOR   = 16'h0010,
    parameter int          FLUSH_TIMEOUT = 8,
    parameter int          CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_fault_trap_ctrl_if.master bus
);

    localparam int            TO_W    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FLUSH_TIMEOUT - 1);

    trap_state_t      state, state_next;
    logic [1:0]       mode;
    logic [15:0]      epc, bad_addr;
    logic [1:0]       cause;
    logic [TO_W-1:0]  flush_cycles;
    logic [CNT_W-1:0] fault_count;

    logic             fault_accept, rti_take;
    logic             flush, stall, redirect;
    logic [15:0]      redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and next-state term gets a default before the case so
    // no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_next   = state;
        flush        = 1'b0;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        fault_accept = 1'b0;
        rti_take     = 1'b0;
        case (state)
            ST_RUN: begin
                fault_accept = (bus.Illegal_PC || bus.Illegal_Memory) && (mode == MODE_USER);
                // Fault and Rti together is illegal; the fault takes priority.
                rti_take     = bus.Rti && (mode == MODE_KERNEL) && !fault_accept;
                if (fault_accept) begin
                    state_next = ST_FLUSH;
                end
                if (rti_take) begin
                    redirect    = 1'b1;
                    redirect_pc = epc;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                stall = 1'b1;
                if (bus.Flush_Done || (flush_cycles == TO_LAST)) begin
                    state_next = ST_SAVE;
                end
            end
            ST_SAVE: begin
                stall      = 1'b1;
                state_next = ST_VECTOR;
            end
            ST_VECTOR: begin
                redirect    = 1'b1;
                redirect_pc = TRAP_VECTOR;
                state_next  = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // NOTE: all architectural registers are reset because the handler and the
    // checker observe them directly; an X here would leak into mode checks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= MODE_KERNEL;
            epc      <= '0;
            cause    <= '0;
            bad_addr <= '0;
        end else begin
            if (state == ST_SAVE) begin
                mode <= MODE_KERNEL;
            end else if (rti_take) begin
                mode <= MODE_USER;
            end
            if (fault_accept) begin
                epc      <= bus.Fault_PC;
                cause    <= fault_cause(bus.Illegal_PC, bus.Illegal_Memory);
                bad_addr <= bus.Illegal_Memory ? bus.Fault_Addr : bus.Fault_PC;
            end
        end
    end

    // Counts cycles spent in FLUSH, starting from zero on entry.
    sat_counter #(.W(TO_W)) u_flush_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == ST_FLUSH),
        .clear (state != ST_FLUSH),
        .cnt   (flush_cycles)
    );

    // One increment per completed trap, taken in SAVE.
    sat_counter #(.W(CNT_W)) u_fault_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == ST_SAVE),
        .clear (1'b0),
        .cnt   (fault_count)
    );

    assign bus.Mode        = mode;
    assign bus.Flush       = flush;
    assign bus.Stall       = stall;
    assign bus.Redirect    = redirect;
    assign bus.Redirect_PC = redirect_pc;
    assign bus.EPC         = epc;
    assign bus.Cause       = cause;
    assign bus.Bad_Addr    = bad_addr;
    assign bus.Fault_Count = fault_count;

endmodule

// File: tb/tb_mem_fault_trap_ctrl.sv
// Self-checking bench for mem_fault_trap_ctrl: directed trap / return scenarios
// followed by randomized traps, compared against a transaction-level model.
module tb_mem_fault_trap_ctrl;

    localparam logic [15:0] TRAP_VECTOR   = 16'h0010;
    localparam int          FLUSH_TIMEOUT = 8;
    localparam logic [1:0]  KERNEL        = 2'b00;
    localparam logic [1:0]  USER          = 2'b01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_fault_trap_ctrl_if #(.CNT_W(8)) bus ();

    mem_fault_trap_ctrl #(
        .TRAP_VECTOR   (TRAP_VECTOR),
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Architectural model of what the handler should see.
    logic [1:0]  m_mode;
    logic [15:0] m_epc, m_bad;
    logic [1:0]  m_cause;
    int          m_traps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
        return (m_traps > 255) ? 32'd255 : 32'(m_traps);
    endfunction

    task automatic model_reset();
        m_mode  = KERNEL;
        m_epc   = '0;
        m_bad   = '0;
        m_cause = '0;
        m_traps = 0;
    endtask

    task automatic idle_inputs();
        bus.Illegal_PC     = 1'b0;
        bus.Illegal_Memory = 1'b0;
        bus.Fault_PC       = '0;
        bus.Fault_Addr     = '0;
        bus.Rti            = 1'b0;
        bus.Flush_Done     = 1'b0;
    endtask

    task automatic check_saved(input string tag);
        check({tag, ".epc"},   32'(bus.EPC),      32'(m_epc));
        check({tag, ".cause"}, 32'(bus.Cause),    32'(m_cause));
        check({tag, ".bad"},   32'(bus.Bad_Addr), 32'(m_bad));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".flush"},    32'(bus.Flush),       32'd0);
        check({tag, ".stall"},    32'(bus.Stall),       32'd0);
        check({tag, ".redirect"}, 32'(bus.Redirect),    32'd0);
        check({tag, ".rpc"},      32'(bus.Redirect_PC), 32'd0);
        check({tag, ".mode"},     32'(bus.Mode),        32'(m_mode));
        check({tag, ".count"},    32'(bus.Fault_Count), exp_count());
        check_saved(tag);
    endtask

    // Return from trap in kernel mode; random fault flags alongside must be ignored.
    task automatic do_rti(input string tag);
        @(negedge clk);
        idle_inputs();
        bus.Rti            = 1'b1;
        bus.Illegal_PC     = 1'($urandom);
        bus.Illegal_Memory = 1'($urandom);
        bus.Fault_PC       = 16'($urandom);
        bus.Fault_Addr     = 16'($urandom);
        #1;
        check({tag, ".rti_redirect"}, 32'(bus.Redirect),    32'd1);
        check({tag, ".rti_target"},   32'(bus.Redirect_PC), 32'(m_epc));
        check({tag, ".rti_mode_old"}, 32'(bus.Mode),        32'(KERNEL));
        @(negedge clk);
        idle_inputs();
        m_mode = USER;
        #1;
        check({tag, ".rti_mode_new"}, 32'(bus.Mode),     32'(USER));
        check({tag, ".rti_pulse"},    32'(bus.Redirect), 32'd0);
        check_saved({tag, ".rti"});
    endtask

    // One full trap from user mode. d = FLUSH cycle index (0-based) at which
    // Flush_Done rises and stays high; the flush lasts min(d+1, FLUSH_TIMEOUT).
    task automatic do_trap(input string tag, input logic pc_f, input logic mem_f,
                           input logic [15:0] fpc, input logic [15:0] faddr, input int d);
        int f;
        f = (d + 1 < FLUSH_TIMEOUT) ? d + 1 : FLUSH_TIMEOUT;
        @(negedge clk);
        idle_inputs();
        bus.Illegal_PC     = pc_f;
        bus.Illegal_Memory = mem_f;
        bus.Fault_PC       = fpc;
        bus.Fault_Addr     = faddr;
        bus.Rti            = 1'($urandom);
        #1;
        check({tag, ".accept_redirect"}, 32'(bus.Redirect), 32'd0);
        check({tag, ".accept_stall"},    32'(bus.Stall),    32'd0);
        m_epc   = fpc;
        m_cause = {mem_f, pc_f};
        m_bad   = mem_f ? faddr : fpc;
        m_traps++;
        for (int k = 1; k <= f + 2; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k <= f) begin
                bus.Illegal_PC     = 1'($urandom);
                bus.Illegal_Memory = 1'($urandom);
                bus.Fault_PC       = 16'($urandom);
                bus.Fault_Addr     = 16'($urandom);
                bus.Flush_Done     = (k - 1 >= d);
            end
            #1;
            if (k <= f) begin
                check({tag, ".flush"},       32'(bus.Flush),    32'd1);
                check({tag, ".flush_stall"}, 32'(bus.Stall),    32'd1);
                check({tag, ".flush_redir"}, 32'(bus.Redirect), 32'd0);
                check({tag, ".flush_mode"},  32'(bus.Mode),     32'(USER));
            end else if (k == f + 1) begin
                check({tag, ".save_flush"},  32'(bus.Flush),    32'd0);
                check({tag, ".save_stall"},  32'(bus.Stall),    32'd1);
                check({tag, ".save_redir"},  32'(bus.Redirect), 32'd0);
                check({tag, ".save_mode"},   32'(bus.Mode),     32'(USER));
            end else begin
                check({tag, ".vec_redir"},   32'(bus.Redirect),    32'd1);
                check({tag, ".vec_target"},  32'(bus.Redirect_PC), 32'(TRAP_VECTOR));
                check({tag, ".vec_stall"},   32'(bus.Stall),       32'd0);
                check({tag, ".vec_mode"},    32'(bus.Mode),        32'(KERNEL));
                check({tag, ".vec_count"},   32'(bus.Fault_Count), exp_count());
            end
            check_saved(tag);
        end
        m_mode = KERNEL;
        @(negedge clk);
        idle_inputs();
        #1;
        check_idle({tag, ".done"});
    endtask

    initial begin
        logic pf, mf;
        idle_inputs();
        model_reset();

        // Reset state
        #2;
        check_idle("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle("post_reset");

        // Enter user mode through Rti (EPC is 0 after reset)
        do_rti("boot");

        // Directed traps
        do_trap("pc_fault",   1'b1, 1'b0, 16'h0042, 16'h1234, 0);
        do_rti("ret1");
        do_trap("mem_fault",  1'b0, 1'b1, 16'h0300, 16'h00F0, 0);
        do_rti("ret2");
        do_trap("both_fault", 1'b1, 1'b1, 16'h0456, 16'h0020, 2);
        do_rti("ret3");
        do_trap("timeout",    1'b1, 1'b0, 16'h0500, 16'h0000, 20);
        do_rti("ret4");

        // Rti in user mode is ignored
        @(negedge clk);
        bus.Rti = 1'b1;
        #1;
        check("user_rti.redirect", 32'(bus.Redirect), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check_idle("user_rti");

        // Fault flags in kernel mode are ignored
        do_trap("pre_kernel", 1'b0, 1'b1, 16'h0600, 16'h0080, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.Illegal_PC     = 1'b1;
            bus.Illegal_Memory = 1'($urandom);
            bus.Fault_PC       = 16'($urandom);
            bus.Fault_Addr     = 16'($urandom);
            #1;
            check("kernel_flag.stall", 32'(bus.Stall), 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check_idle("kernel_flag");
        do_rti("ret5");

        // Randomized traps, enough to drive the counter into saturation
        for (int n = 0; n < 260; n++) begin
            pf = 1'($urandom);
            mf = pf ? 1'($urandom) : 1'b1;
            do_trap("rand", pf, mf, 16'($urandom), 16'($urandom), int'($urandom_range(0, 10)));
            do_rti("rand_ret");
        end
        check("saturated", 32'(bus.Fault_Count), 32'hFF);

        // Reset in the middle of FLUSH
        @(negedge clk);
        bus.Illegal_PC = 1'b1;
        bus.Fault_PC   = 16'h0777;
        @(negedge clk);
        idle_inputs();
        #1;
        check("mid_flush.flush", 32'(bus.Flush), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            check_idle("after_reset");
        end

        // Fresh count after reset
        do_rti("boot2");
        do_trap("after_reset_trap", 1'b1, 1'b0, 16'h0200, 16'h0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
